// File: rtl/capture_thresh_loader_if.sv
// capture_thresh_loader_if: load register word, channel stream in, threshold stream and load status out
interface capture_thresh_loader_if #(
  parameter int C_CH_BITS  = 8,
  parameter int C_TH_WIDTH = 16
);
  logic [31:0]           load_word;
  logic                  in_valid;
  logic [C_CH_BITS-1:0]  in_ch;
  logic                  out_valid;
  logic [C_CH_BITS-1:0]  out_ch;
  logic [C_TH_WIDTH-1:0] thresh_out;
  logic                  busy;
  logic                  load_done;
  logic                  load_dropped;
  logic [15:0]           load_count;
  modport master (
    output load_word, in_valid, in_ch,
    input  out_valid, out_ch, thresh_out, busy, load_done, load_dropped, load_count
  );
  modport slave (
    input  load_word, in_valid, in_ch,
    output out_valid, out_ch, thresh_out, busy, load_done, load_dropped, load_count
  );
endinterface

// File: rtl/capture_thresh_loader.sv
// capture_thresh_loader: loads per-channel trigger thresholds from a register word and serves them to a channel stream
module capture_thresh_loader #(
  parameter int                    C_CH_BITS        = 8,
  parameter int                    C_TH_WIDTH       = 16,
  parameter logic [C_TH_WIDTH-1:0] C_DEFAULT_THRESH = 16'h8000
) (
  input logic                    user_clk,
  input logic                    user_rst_n,
  capture_thresh_loader_if.slave bus
);
  localparam int N = 1 << C_CH_BITS;
  typedef enum logic [1:0] {FILL_RST, IDLE, WRITE, FILL} state_t;
  state_t                r_state, w_next;
  logic                  r_strobe, r_strobe_prev, r_all;
  logic [C_CH_BITS-1:0]  r_ch, r_fill_cnt, r_wr_ch, r_rd_addr, r_ch2;
  logic [C_TH_WIDTH-1:0] r_th, r_wr_th, r_rdata;
  logic [C_TH_WIDTH-1:0] r_ram [N];
  logic                  r_v1, r_v2;
  logic [15:0]           r_count;
  logic                  w_edge, w_last, w_busy, w_we, w_done, w_drop;
  logic [C_CH_BITS-1:0]  w_waddr;
  logic [C_TH_WIDTH-1:0] w_wdata;
  logic                  w_unused;
  // Only the strobe, load_all, channel and threshold fields matter
  assign w_unused = ^bus.load_word[29:0];
  assign w_edge   = r_strobe & ~r_strobe_prev;
  assign w_last   = &r_fill_cnt;
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) r_state <= FILL_RST;
    else             r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_edge ? (r_all ? FILL : WRITE) : IDLE) :
             (r_state == WRITE) ? IDLE :
             (w_last ? IDLE : r_state);
  end
  always_comb begin
    w_busy  = (r_state == FILL_RST) || (r_state == FILL);
    w_we    = w_busy || (r_state == WRITE);
    w_waddr = (r_state == WRITE) ? r_wr_ch : r_fill_cnt;
    w_wdata = (r_state == FILL_RST) ? C_DEFAULT_THRESH : r_wr_th;
    w_done  = (r_state == WRITE) || ((r_state == FILL) && w_last);
    w_drop  = w_edge && (r_state != IDLE);
  end
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      r_strobe      <= 1'b1;
      r_strobe_prev <= 1'b1;
      r_all         <= 1'b0;
      r_ch          <= '0;
      r_th          <= '0;
      r_fill_cnt    <= '0;
      r_wr_ch       <= '0;
      r_wr_th       <= C_DEFAULT_THRESH;
      r_count       <= '0;
    end else begin
      r_strobe      <= bus.load_word[31];
      r_strobe_prev <= r_strobe;
      r_all         <= bus.load_word[30];
      r_ch          <= bus.load_word[16 +: C_CH_BITS];
      r_th          <= bus.load_word[C_TH_WIDTH-1:0];
      r_fill_cnt    <= w_busy ? r_fill_cnt + 1'b1 : '0;
      if ((r_state == IDLE) && w_edge) begin
        r_wr_ch <= r_ch;
        r_wr_th <= r_th;
      end
      if (w_done) r_count <= r_count + 16'd1;
    end
  always_ff @(posedge user_clk)
    if (w_we) r_ram[w_waddr] <= w_wdata;
  // Read-first: a same-cycle write to the read address is seen on the next read
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_rd_addr <= '0;
      r_ch2     <= '0;
      r_rdata   <= '0;
    end else begin
      r_v1      <= bus.in_valid;
      r_rd_addr <= bus.in_ch;
      r_v2      <= r_v1;
      r_ch2     <= r_rd_addr;
      if (r_v1) r_rdata <= r_ram[r_rd_addr];
    end
  assign bus.out_valid    = r_v2;
  assign bus.out_ch       = r_ch2;
  assign bus.thresh_out   = r_rdata;
  assign bus.busy         = w_busy;
  assign bus.load_done    = w_done;
  assign bus.load_dropped = w_drop;
  assign bus.load_count   = r_count;
endmodule
